// File: rtl/rf_scoreboard_ctrl.sv
// rf_scoreboard_ctrl
//   Issue/hazard controller for the decode-stage register file. Keeps a
//   saturating pending-write counter per register and a global in-flight
//   count, stalls issue on RAW hazards, saturated destinations or a full
//   pipeline, and retires pending writes at writeback. A small drain FSM
//   blocks non-NOP issue and reports when the pipeline is empty.
//
//   Optional feature macro: RF_SB_FORWARD_EN
//     When defined, a RAW hazard on a source is ignored if this cycle's
//     writeback retires the last pending write to that source.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   issue_*_i             decode-stage instruction (valid, code, rd, rs, rt)
//   issue_ready_o         combinational; issue fires on valid & ready
//   wb_*_i                retiring instruction (valid, code, rd)
//   drain_req_i           request pipeline quiesce
//   drain_done_o          pipeline empty, issue blocked (registered)
//   busy_vec_o            per-register pending-write flags (registered)
//   inflight_o            total outstanding writes
//   err_underflow_o       sticky: retire on a register with nothing pending
module rf_scoreboard_ctrl #(
  parameter int REG_SIZE     = 5,
  parameter int CODE_SIZE    = 6,
  parameter int REG_CAPACITY = 32,
  parameter int CNT_SIZE     = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_SIZE     = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic [CODE_SIZE-1:0]    issue_code_i,
  input  logic [REG_SIZE-1:0]     issue_rd_i,
  input  logic [REG_SIZE-1:0]     issue_rs_i,
  input  logic [REG_SIZE-1:0]     issue_rt_i,
  output logic                    issue_ready_o,
  input  logic                    wb_valid_i,
  input  logic [CODE_SIZE-1:0]    wb_code_i,
  input  logic [REG_SIZE-1:0]     wb_rd_i,
  input  logic                    drain_req_i,
  output logic                    drain_done_o,
  output logic [REG_CAPACITY-1:0] busy_vec_o,
  output logic [INF_SIZE-1:0]     inflight_o,
  output logic                    err_underflow_o
);

  localparam logic [CODE_SIZE-1:0] OP_NOP = CODE_SIZE'(0);
  localparam logic [CODE_SIZE-1:0] OP_ALU = CODE_SIZE'(1);
  localparam logic [CODE_SIZE-1:0] OP_LW  = CODE_SIZE'(2);
  localparam logic [CODE_SIZE-1:0] OP_SW  = CODE_SIZE'(3);
  localparam logic [CNT_SIZE-1:0]  CNT_MAX = '1;
  localparam logic [INF_SIZE-1:0]  INF_MAX = INF_SIZE'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                    state_q;
  logic [CNT_SIZE-1:0]       cnt_q [REG_CAPACITY];
  logic [CNT_SIZE-1:0]       cnt_d [REG_CAPACITY];
  logic [INF_SIZE-1:0]       inflight_q, inflight_d;
  logic [REG_CAPACITY-1:0]   busy_q;
  logic                      drain_done_q, err_q;

  logic iss_wr, uses_rs, uses_rt, wb_wr, wb_ret, wb_unf;
  logic fwd_rs, fwd_rt, raw_rs, raw_rt, sat, full, st_blk, fire;

  always_comb begin
    iss_wr  = (issue_code_i == OP_ALU) || (issue_code_i == OP_LW);
    uses_rs = iss_wr || (issue_code_i == OP_SW);
    uses_rt = (issue_code_i == OP_ALU) || (issue_code_i == OP_SW);

    // A writing WB to a nonzero register either retires a pending write or,
    // if nothing is pending, is an underflow that leaves all counts intact.
    wb_wr  = wb_valid_i && ((wb_code_i == OP_ALU) || (wb_code_i == OP_LW)) &&
             (wb_rd_i != '0);
    wb_ret = wb_wr && (cnt_q[wb_rd_i] != '0);
    wb_unf = wb_wr && (cnt_q[wb_rd_i] == '0);

`ifdef RF_SB_FORWARD_EN
    // RF writes on negedge, so the read sees the retiring value.
    fwd_rs = wb_ret && (wb_rd_i == issue_rs_i) && (cnt_q[issue_rs_i] == CNT_SIZE'(1));
    fwd_rt = wb_ret && (wb_rd_i == issue_rt_i) && (cnt_q[issue_rt_i] == CNT_SIZE'(1));
`else
    fwd_rs = 1'b0;
    fwd_rt = 1'b0;
`endif

    raw_rs = uses_rs && (issue_rs_i != '0) && (cnt_q[issue_rs_i] != '0) && !fwd_rs;
    raw_rt = uses_rt && (issue_rt_i != '0) && (cnt_q[issue_rt_i] != '0) && !fwd_rt;
    sat    = iss_wr && (issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX);
    // A retiring WB frees a slot this cycle, so a full pipeline can still accept.
    full   = iss_wr && (issue_rd_i != '0) && (inflight_q == INF_MAX) && !wb_ret;
    st_blk = (state_q != S_RUN) && (issue_code_i != OP_NOP);

    issue_ready_o = !(st_blk || raw_rs || raw_rt || sat || full);
    fire = issue_valid_i && issue_ready_o && iss_wr && (issue_rd_i != '0);

    // Saturation and full checks above guarantee neither counter wraps.
    for (int n = 0; n < REG_CAPACITY; n++) begin
      cnt_d[n] = cnt_q[n]
               + CNT_SIZE'(fire   && (issue_rd_i == REG_SIZE'(n)))
               - CNT_SIZE'(wb_ret && (wb_rd_i    == REG_SIZE'(n)));
    end
    inflight_d = inflight_q + INF_SIZE'(fire) - INF_SIZE'(wb_ret);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < REG_CAPACITY; n++) cnt_q[n] <= '0;
      inflight_q   <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
      state_q      <= S_RUN;
      drain_done_q <= 1'b0;
    end else begin
      for (int n = 0; n < REG_CAPACITY; n++) begin
        cnt_q[n]  <= cnt_d[n];
        busy_q[n] <= (cnt_d[n] != '0);
      end
      inflight_q <= inflight_d;
      if (wb_unf) err_q <= 1'b1;

      case (state_q)
        S_RUN: begin
          if (drain_req_i) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!drain_req_i) begin
            state_q <= S_RUN;
          end else if (inflight_q == '0) begin
            state_q      <= S_DONE;
            drain_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!drain_req_i) begin
            state_q      <= S_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_vec_o      = busy_q;
  assign inflight_o      = inflight_q;
  assign drain_done_o    = drain_done_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_rf_scoreboard_ctrl.sv
// Directed table-driven bench for rf_scoreboard_ctrl, plus hand-written
// sequences for same-cycle fire/retire and a bounded drain handshake.
module tb_rf_scoreboard_ctrl;

  localparam logic [5:0] N = 6'd0, A = 6'd1, L = 6'd2, S = 6'd3;
`ifdef RF_SB_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_ready, wb_valid, drain_req, drain_done, err_underflow;
  logic [5:0]  issue_code, wb_code;
  logic [4:0]  issue_rd, issue_rs, issue_rt, wb_rd;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_scoreboard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_code_i(issue_code),
    .issue_rd_i(issue_rd), .issue_rs_i(issue_rs), .issue_rt_i(issue_rt),
    .issue_ready_o(issue_ready),
    .wb_valid_i(wb_valid), .wb_code_i(wb_code), .wb_rd_i(wb_rd),
    .drain_req_i(drain_req), .drain_done_o(drain_done),
    .busy_vec_o(busy_vec), .inflight_o(inflight), .err_underflow_o(err_underflow)
  );

  typedef struct {
    logic        rst, iv;
    logic [5:0]  ic;
    logic [4:0]  rd, rs, rt;
    logic        wv;
    logic [5:0]  wc;
    logic [4:0]  wrd;
    logic        dr, crdy, rdy;
    logic [31:0] busy;
    logic [2:0]  inf;
    logic        dd, err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic iv, logic [5:0] ic, logic [4:0] rd, logic [4:0] rs,
                              logic [4:0] rt, logic wv, logic [5:0] wc, logic [4:0] wrd, logic dr,
                              logic crdy, logic rdy, logic [31:0] busy, logic [2:0] inf,
                              logic dd, logic err);
    vec_t v;
    v.rst = r; v.iv = iv; v.ic = ic; v.rd = rd; v.rs = rs; v.rt = rt;
    v.wv = wv; v.wc = wc; v.wrd = wrd; v.dr = dr; v.crdy = crdy; v.rdy = rdy;
    v.busy = busy; v.inf = inf; v.dd = dd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [5:0] ic, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic wv,
                       input logic [5:0] wc, input logic [4:0] wrd, input logic dr);
    issue_valid = iv; issue_code = ic; issue_rd = rd; issue_rs = rs; issue_rt = rt;
    wb_valid = wv; wb_code = wc; wb_rd = wrd; drain_req = dr;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, N, 0, 0, 0, 0, N, 0, 0);

    //             rst iv ic rd rs rt wv wc wrd dr crdy rdy  busy        inf dd err
    tv.push_back(mk(1, 0, N, 0, 0, 0, 0, N, 0, 0, 0, 0,   32'h0,      0, 0, 0)); // reset
    tv.push_back(mk(0, 1, A, 5, 0, 0, 0, N, 0, 0, 1, 1,   32'h20,     1, 0, 0)); // ALU rd5
    tv.push_back(mk(0, 1, S, 0, 5, 0, 0, N, 0, 0, 1, 0,   32'h20,     1, 0, 0)); // SW rs5 RAW
    tv.push_back(mk(0, 1, A, 0, 5, 0, 1, A, 5, 0, 1, FWD, 32'h0,      0, 0, 0)); // WB5 + read5
    tv.push_back(mk(0, 1, A, 0, 5, 0, 0, N, 0, 0, 1, 1,   32'h0,      0, 0, 0)); // read5 clear
    tv.push_back(mk(0, 1, A, 0, 0, 0, 1, A, 0, 0, 1, 1,   32'h0,      0, 0, 0)); // r0 ignored
    tv.push_back(mk(0, 1, L, 1, 0, 0, 0, N, 0, 0, 1, 1,   32'h2,      1, 0, 0));
    tv.push_back(mk(0, 1, L, 2, 0, 0, 0, N, 0, 0, 1, 1,   32'h6,      2, 0, 0));
    tv.push_back(mk(0, 1, L, 3, 0, 0, 0, N, 0, 0, 1, 1,   32'hE,      3, 0, 0));
    tv.push_back(mk(0, 1, L, 4, 0, 0, 0, N, 0, 0, 1, 1,   32'h1E,     4, 0, 0));
    tv.push_back(mk(0, 1, A, 5, 0, 0, 0, N, 0, 0, 1, 0,   32'h1E,     4, 0, 0)); // full
    tv.push_back(mk(0, 1, A, 5, 0, 0, 1, L, 1, 0, 1, 1,   32'h3C,     4, 0, 0)); // full + WB
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, L, 2, 0, 1, 1,   32'h38,     3, 0, 0));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, L, 3, 0, 1, 1,   32'h30,     2, 0, 0));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, L, 4, 0, 1, 1,   32'h20,     1, 0, 0));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, A, 5, 0, 1, 1,   32'h0,      0, 0, 0));
    tv.push_back(mk(0, 1, A, 7, 0, 0, 0, N, 0, 0, 1, 1,   32'h80,     1, 0, 0));
    tv.push_back(mk(0, 1, A, 7, 0, 0, 0, N, 0, 0, 1, 1,   32'h80,     2, 0, 0));
    tv.push_back(mk(0, 1, A, 7, 0, 0, 0, N, 0, 0, 1, 1,   32'h80,     3, 0, 0));
    tv.push_back(mk(0, 1, A, 7, 0, 0, 0, N, 0, 0, 1, 0,   32'h80,     3, 0, 0)); // saturated
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, A, 9, 0, 1, 1,   32'h80,     3, 0, 1)); // underflow
    tv.push_back(mk(0, 1, S, 0, 0, 7, 0, N, 0, 0, 1, 0,   32'h80,     3, 0, 1)); // SW rt RAW
    tv.push_back(mk(0, 1, L, 1, 0, 7, 0, N, 0, 0, 1, 1,   32'h82,     4, 0, 1)); // LW ignores rt
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, A, 7, 0, 1, 1,   32'h82,     3, 0, 1));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, A, 7, 0, 1, 1,   32'h82,     2, 0, 1));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 0, N, 0, 1, 1, 1,   32'h82,     2, 0, 1)); // -> DRAIN
    tv.push_back(mk(0, 1, A, 0, 0, 0, 0, N, 0, 1, 1, 0,   32'h82,     2, 0, 1)); // ALU blocked
    tv.push_back(mk(0, 1, N, 0, 0, 0, 0, N, 0, 1, 1, 1,   32'h82,     2, 0, 1)); // NOP ok
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, A, 7, 1, 1, 1,   32'h2,      1, 0, 1));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 1, L, 1, 1, 1, 1,   32'h0,      0, 0, 1));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 0, N, 0, 1, 1, 1,   32'h0,      0, 1, 1)); // -> DONE
    tv.push_back(mk(0, 1, A, 0, 0, 0, 0, N, 0, 1, 1, 0,   32'h0,      0, 1, 1)); // DONE blocks
    tv.push_back(mk(0, 0, N, 0, 0, 0, 0, N, 0, 0, 1, 1,   32'h0,      0, 0, 1)); // -> RUN
    tv.push_back(mk(0, 1, A, 8, 0, 0, 0, N, 0, 0, 1, 1,   32'h100,    1, 0, 1));
    tv.push_back(mk(0, 0, N, 0, 0, 0, 0, N, 0, 1, 1, 1,   32'h100,    1, 0, 1)); // -> DRAIN
    tv.push_back(mk(0, 0, N, 0, 0, 0, 0, N, 0, 0, 1, 1,   32'h100,    1, 0, 1)); // drop -> RUN
    tv.push_back(mk(0, 1, A, 9, 0, 0, 0, N, 0, 0, 1, 1,   32'h300,    2, 0, 1)); // RUN again
    tv.push_back(mk(1, 0, N, 0, 0, 0, 0, N, 0, 1, 0, 0,   32'h0,      0, 0, 0)); // rst mid-op
    tv.push_back(mk(0, 1, S, 0, 8, 9, 0, N, 0, 0, 1, 1,   32'h0,      0, 0, 0)); // state gone

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst;
      drive(tv[i].iv, tv[i].ic, tv[i].rd, tv[i].rs, tv[i].rt,
            tv[i].wv, tv[i].wc, tv[i].wrd, tv[i].dr);
      #1;
      if (tv[i].crdy) chk($sformatf("v%0d ready", i), {31'd0, issue_ready}, {31'd0, tv[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d busy", i), busy_vec, tv[i].busy);
      chk($sformatf("v%0d inflight", i), {29'd0, inflight}, {29'd0, tv[i].inf});
      chk($sformatf("v%0d drain_done", i), {31'd0, drain_done}, {31'd0, tv[i].dd});
      chk($sformatf("v%0d err", i), {31'd0, err_underflow}, {31'd0, tv[i].err});
    end

    // Same-cycle fire and retire on one register: counts unchanged.
    @(negedge clk); rst = 1'b0;
    drive(1, A, 3, 0, 0, 0, N, 0, 0);
    @(posedge clk); #1;
    chk("seq fire rd3 inflight", {29'd0, inflight}, 32'd1);
    @(negedge clk);
    drive(1, A, 3, 0, 0, 1, A, 3, 0);
    #1 chk("seq fire+retire ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk); #1;
    chk("seq fire+retire busy", busy_vec, 32'h8);
    chk("seq fire+retire inflight", {29'd0, inflight}, 32'd1);

    // Drain while the last write retires; bounded wait for drain_done.
    @(negedge clk);
    drive(0, N, 0, 0, 0, 1, A, 3, 1);
    @(negedge clk);
    drive(0, N, 0, 0, 0, 0, N, 0, 1);
    begin
      int k;
      k = 0;
      while (drain_done !== 1'b1 && k < 8) begin
        @(posedge clk); #1;
        k++;
      end
      chk("seq drain_done within budget", {31'd0, drain_done}, 32'd1);
      chk("seq drain err clean", {31'd0, err_underflow}, 32'd0);
    end
    @(negedge clk);
    drive(0, N, 0, 0, 0, 0, N, 0, 0);
    @(posedge clk); #1;
    chk("seq drain release", {31'd0, drain_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
